mem_access_unit: RTL and testbench

Memory-stage load/store unit placed directly downstream of the ALU. It consumes the ALU result (effective address), the memory op code and the store data (rt). It runs a multicycle request/response transaction on an SRAM-like data bus, stalls the pipeline while the transaction is in flight, and returns byte-aligned, sign- or zero-extended load data. It also detects misaligned addresses and reports them as AdEL/AdES exceptions to the exception logic.

---
 rtl/mem_access_unit_pkg.sv | 62 ++++++
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit_align.sv | 68 ++++++
 rtl/mem_access_unit.sv | 149 ++++++++++++++
 tb/tb_mem_access_unit.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
// Shared definitions for the memory-stage load/store unit:
//   - EXE_*_OP codes that the unit acts on (the rest of the ALU op space is ignored)
//   - bus size codes (byte / half / word)
//   - 3-bit LSU state encodings
//   - the registered request record and op classification helpers
package mem_access_unit_pkg;

  localparam int LSU_ADDR_W = 32;

  // Memory op codes as produced by the decode/EXE stage
  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  // Bus transfer size codes
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  // LSU state encodings
  localparam logic [2:0] LSU_IDLE  = 3'd0;
  localparam logic [2:0] LSU_ADDR  = 3'd1;
  localparam logic [2:0] LSU_DATA  = 3'd2;
  localparam logic [2:0] LSU_DONE  = 3'd3;
  localparam logic [2:0] LSU_DRAIN = 3'd4;

  // Everything captured when a transaction starts
  typedef struct packed {
    logic [7:0]            op;
    logic                  wr;
    logic [1:0]            size;
    logic [3:0]            wstrb;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_ADDR_W-1:0] wdata;
  } lsu_req_t;

  function automatic logic lsu_is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic lsu_is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  // Natural alignment: words on 4-byte, halves on 2-byte, bytes anywhere
  function automatic logic lsu_aligned(input logic [7:0] op, input logic [1:0] addr_lo);
    logic ok;
    case (op)
      EXE_LW_OP, EXE_SW_OP:             ok = (addr_lo == 2'b00);
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: ok = ~addr_lo[0];
      default:                          ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if
// SRAM-like data bus between the load/store unit (master) and memory (slave).
//   data_req     master->slave  request valid, held until data_addr_ok
//   data_wr      master->slave  1 = write
//   data_size    master->slave  0 byte, 1 half, 2 word
//   data_addr    master->slave  full byte address
//   data_wdata   master->slave  lane-replicated write data
//   data_wstrb   master->slave  byte strobes (0000 on reads)
//   data_addr_ok slave->master  request accepted
//   data_data_ok slave->master  read data valid / write complete
//   data_rdata   slave->master  read data
interface mem_access_unit_if #(
  parameter int ADDR_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [ADDR_W-1:0] data_wdata;
  logic [3:0]        data_wstrb;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [ADDR_W-1:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access_unit_align.sv
// mem_access_unit_align
// Purely combinational lane logic for the load/store unit.
// Store side (driven from the instruction currently in MEM):
//   i_st_op, i_st_addr_lo, i_st_data -> o_size, o_wstrb, o_wdata
// Load side (driven from the registered request and the bus read word):
//   i_ld_op, i_ld_addr_lo, i_ld_word -> o_ld_data (aligned, sign/zero extended)
module mem_access_unit_align
  import mem_access_unit_pkg::*;
(
  input  logic [7:0]  i_st_op,
  input  logic [1:0]  i_st_addr_lo,
  input  logic [31:0] i_st_data,
  output logic [1:0]  o_size,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  input  logic [7:0]  i_ld_op,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic signed [7:0]  w_byte;
  logic signed [15:0] w_half;

  always_comb begin
    o_size  = SIZE_WORD;
    o_wstrb = 4'b0000;
    o_wdata = i_st_data;
    case (i_st_op)
      EXE_LB_OP, EXE_LBU_OP: o_size = SIZE_BYTE;
      EXE_LH_OP, EXE_LHU_OP: o_size = SIZE_HALF;
      EXE_SB_OP: begin
        o_size  = SIZE_BYTE;
        o_wstrb = 4'b0001 << i_st_addr_lo;
        o_wdata = {4{i_st_data[7:0]}};
      end
      EXE_SH_OP: begin
        o_size  = SIZE_HALF;
        o_wstrb = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_data[15:0]}};
      end
      EXE_SW_OP: o_wstrb = 4'b1111;
      default: ;
    endcase
  end

  always_comb begin
    case (i_ld_addr_lo)
      2'd0:    w_byte = i_ld_word[7:0];
      2'd1:    w_byte = i_ld_word[15:8];
      2'd2:    w_byte = i_ld_word[23:16];
      default: w_byte = i_ld_word[31:24];
    endcase
    w_half = i_ld_addr_lo[1] ? i_ld_word[31:16] : i_ld_word[15:0];
  end

  // Signed casts widen with sign extension; unsigned variants pad with zeros
  always_comb begin
    case (i_ld_op)
      EXE_LB_OP:  o_ld_data = 32'(w_byte);
      EXE_LBU_OP: o_ld_data = {24'd0, w_byte};
      EXE_LH_OP:  o_ld_data = 32'(w_half);
      EXE_LHU_OP: o_ld_data = {16'd0, w_half};
      default:    o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
// Memory-stage load/store unit. Takes the ALU effective address, op code and
// store data, runs one request/response transaction on the data bus, stalls
// the pipeline while it is in flight and returns aligned load data.
// Misaligned accesses never reach the bus; they raise AdEL/AdES instead.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   valid_i           MEM-stage instruction valid
//   op_i              EXE_*_OP code
//   addr_i, wdata_i   effective address, store data (rt)
//   flush_i           pipeline flush
//   stall_o           hold the pipeline
//   rdata_o           aligned load result (held until next completion)
//   rdata_valid_o     one-cycle load completion strobe
//   adel_o, ades_o    load / store address error
//   badvaddr_o        faulting address
//   bus               data bus master
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [7:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [ADDR_W-1:0] rdata_o,
  output logic              rdata_valid_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] badvaddr_o,
  mem_access_unit_if.master bus
);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  lsu_req_t          r_req;
  logic [ADDR_W-1:0] r_rdata;

  logic              w_is_load;
  logic              w_is_store;
  logic              w_is_mem;
  logic              w_aligned;
  logic              w_idle;
  logic              w_start;
  logic              w_exc;
  logic              w_resp_done;
  logic [1:0]        w_size;
  logic [3:0]        w_wstrb;
  logic [ADDR_W-1:0] w_wdata;
  logic [ADDR_W-1:0] w_ld_data;

  assign w_is_load  = lsu_is_load(op_i);
  assign w_is_store = lsu_is_store(op_i);
  assign w_is_mem   = w_is_load | w_is_store;
  assign w_aligned  = lsu_aligned(op_i, addr_i[1:0]);
  assign w_idle     = (r_state == LSU_IDLE);

  // Both new transactions and exceptions are only taken from IDLE; in every
  // other state the instruction on the inputs is either the one in flight or
  // one that must wait for the bus to drain first.
  assign w_start = ~rst & valid_i & w_is_mem &  w_aligned & ~flush_i & w_idle;
  assign w_exc   = ~rst & valid_i & w_is_mem & ~w_aligned & ~flush_i & w_idle;

  mem_access_unit_align u_align (
    .i_st_op      (op_i),
    .i_st_addr_lo (addr_i[1:0]),
    .i_st_data    (wdata_i),
    .o_size       (w_size),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .i_ld_op      (r_req.op),
    .i_ld_addr_lo (r_req.addr[1:0]),
    .i_ld_word    (bus.data_rdata),
    .o_ld_data    (w_ld_data)
  );

  // A flush while the request is still unaccepted can simply drop it; once
  // accepted, the outstanding response must be drained before the bus is
  // reused. A response that coincides with the flush retires the access.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LSU_IDLE: begin
        if (w_start) w_state_nxt = LSU_ADDR;
      end
      LSU_ADDR: begin
        if (flush_i) begin
          if (!bus.data_addr_ok)      w_state_nxt = LSU_IDLE;
          else if (bus.data_data_ok)  w_state_nxt = LSU_IDLE;
          else                        w_state_nxt = LSU_DRAIN;
        end else if (bus.data_addr_ok) begin
          w_state_nxt = bus.data_data_ok ? LSU_DONE : LSU_DATA;
        end
      end
      LSU_DATA: begin
        if (bus.data_data_ok) w_state_nxt = flush_i ? LSU_IDLE : LSU_DONE;
        else if (flush_i)     w_state_nxt = LSU_DRAIN;
      end
      LSU_DONE:  w_state_nxt = LSU_IDLE;
      LSU_DRAIN: begin
        if (bus.data_data_ok) w_state_nxt = LSU_IDLE;
      end
      default:   w_state_nxt = LSU_IDLE;
    endcase
  end

  assign w_resp_done = (w_state_nxt == LSU_DONE);

  // Request capture / response capture boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LSU_IDLE;
      r_req   <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_req <= '{op: op_i, wr: w_is_store, size: w_size, wstrb: w_wstrb,
                   addr: addr_i, wdata: w_wdata};
      end
      if (w_resp_done && !r_req.wr) r_rdata <= w_ld_data;
    end
  end

  assign stall_o = w_start
                 | (r_state == LSU_ADDR)
                 | (r_state == LSU_DATA)
                 | ((r_state == LSU_DRAIN) & valid_i & w_is_mem);

  assign rdata_o       = r_rdata;
  assign rdata_valid_o = (r_state == LSU_DONE) & ~r_req.wr;

  assign adel_o     = w_exc & w_is_load;
  assign ades_o     = w_exc & w_is_store;
  assign badvaddr_o = w_exc ? addr_i : '0;

  assign bus.data_req   = (r_state == LSU_ADDR);
  assign bus.data_wr    = r_req.wr;
  assign bus.data_size  = r_req.size;
  assign bus.data_addr  = r_req.addr;
  assign bus.data_wdata = r_req.wdata;
  assign bus.data_wstrb = r_req.wstrb;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        flush_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        adel_o;
  logic        ades_o;
  logic [31:0] badvaddr_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .op_i          (op_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .flush_i       (flush_i),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .adel_o        (adel_o),
    .ades_o        (ades_o),
    .badvaddr_o    (badvaddr_o),
    .bus           (bus)
  );

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [7:0] op);
    if (op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_SB_OP) return 1;
    if (op == EXE_LH_OP || op == EXE_LHU_OP || op == EXE_SH_OP) return 2;
    return 4;
  endfunction

  function automatic bit m_is_load(input logic [7:0] op);
    return op == EXE_LB_OP || op == EXE_LBU_OP || op == EXE_LH_OP ||
           op == EXE_LHU_OP || op == EXE_LW_OP;
  endfunction

  function automatic bit m_is_store(input logic [7:0] op);
    return op == EXE_SB_OP || op == EXE_SH_OP || op == EXE_SW_OP;
  endfunction

  function automatic bit m_aligned(input logic [7:0] op, input logic [31:0] addr);
    return (addr % m_bytes(op)) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] addr,
                                         input logic [31:0] word);
    longint v;
    int     n;
    n = m_bytes(op);
    v = word;
    v = v >> (8 * (addr % 4));
    if (n < 4) v = v % (longint'(1) << (8 * n));
    if ((op == EXE_LB_OP || op == EXE_LH_OP) && v >= (longint'(1) << (8 * n - 1)))
      v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [7:0] op, input logic [31:0] addr);
    int n;
    if (!m_is_store(op)) return 4'b0000;
    n = m_bytes(op);
    return 4'(((1 << n) - 1) << (addr % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] op, input logic [31:0] d);
    case (m_bytes(op))
      1:       return {24'd0, d[7:0]} * 32'h0101_0101;
      2:       return {16'd0, d[15:0]} * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [1:0] m_size(input logic [7:0] op);
    case (m_bytes(op))
      1:       return 2'd0;
      2:       return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one access until the pipeline is released, acting as the memory
  // slave: addr_ok after alat waiting request cycles, data_ok dlat cycles later.
  task automatic run_access(input logic [7:0] op, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int alat, input int dlat,
                            output int stalls, output int vcount,
                            output logic [31:0] got_rdata,
                            output logic [31:0] q_addr, output logic q_wr,
                            output logic [1:0] q_size, output logic [3:0] q_wstrb,
                            output logic [31:0] q_wdata, output int req_cycles);
    int phase;
    int acnt;
    int dcnt;
    bit fin;
    stalls = 0; vcount = 0; got_rdata = '0; q_addr = '0; q_wr = 1'b0;
    q_size = '0; q_wstrb = '0; q_wdata = '0; req_cycles = 0;
    phase = 0; acnt = 0; dcnt = 0; fin = 1'b0;
    valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd; flush_i = 1'b0;
    for (int c = 0; c < 64 && !fin; c++) begin
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      if (phase == 0 && bus.data_req) begin
        if (acnt == alat) begin
          bus.data_addr_ok = 1'b1;
          q_addr = bus.data_addr; q_wr = bus.data_wr; q_size = bus.data_size;
          q_wstrb = bus.data_wstrb; q_wdata = bus.data_wdata;
          phase = 1;
          if (dlat == 0) begin
            bus.data_data_ok = 1'b1; bus.data_rdata = rd; phase = 2;
          end
        end else begin
          acnt++;
        end
      end else if (phase == 1) begin
        dcnt++;
        if (dcnt == dlat) begin
          bus.data_data_ok = 1'b1; bus.data_rdata = rd; phase = 2;
        end
      end
      #4;
      if (bus.data_req) req_cycles++;
      if (stall_o) stalls++;
      if (rdata_valid_o) begin
        vcount++;
        got_rdata = rdata_o;
      end
      if (phase == 2 && !stall_o) fin = 1'b1;
      cyc();
    end
    valid_i = 1'b0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    #4;
    if (rdata_valid_o) vcount++;
    cyc();
    if (!fin) stalls = -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; op_i = EXE_LW_OP; addr_i = 32'h101;
    wdata_i = '0; flush_i = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = '0;
    repeat (3) cyc();
    #4;
    checks++;
    if ({stall_o, rdata_valid_o, adel_o, ades_o} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=0000", {stall_o, rdata_valid_o, adel_o, ades_o});
    end
    checks++;
    if ({rdata_o, badvaddr_o} !== 64'd0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=0/0", rdata_o, badvaddr_o);
    end
    checks++;
    if ({bus.data_req, bus.data_wr, bus.data_size, bus.data_wstrb, bus.data_addr, bus.data_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_bus req=%b addr=%h wstrb=%b exp all zero", bus.data_req, bus.data_addr, bus.data_wstrb);
    end
    cyc();
    rst = 1'b0; valid_i = 1'b0;
    cyc();
  endtask

  task automatic test_lw_latency();
    int s, v, rq;
    logic [31:0] rd, qa, qd;
    logic qw;
    logic [1:0] qs;
    logic [3:0] qb;
    run_access(EXE_LW_OP, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, s, v, rd, qa, qw, qs, qb, qd, rq);
    checks++;
    if (s !== 3) begin failures++; $display("FAIL lw_stall_cycles got=%0d exp=3", s); end
    checks++;
    if (v !== 1) begin failures++; $display("FAIL lw_valid_cycles got=%0d exp=1", v); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", rd); end
    checks++;
    if ({qw, qs, qb} !== {1'b0, 2'd2, 4'b0000}) begin
      failures++; $display("FAIL lw_req_attr got wr=%b size=%0d wstrb=%b exp 0/2/0000", qw, qs, qb);
    end
    checks++;
    if (qa !== 32'h100 || rq !== 1) begin
      failures++; $display("FAIL lw_req_addr got=%h reqcyc=%0d exp=00000100/1", qa, rq);
    end
    #4;
    checks++;
    if (rdata_o !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata_hold got=%h exp=deadbeef", rdata_o); end
    cyc();
  endtask

  task automatic test_load_ext();
    logic [7:0]  ops [4] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP};
    logic [31:0] ads [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] exp [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF};
    int s, v, rq;
    logic [31:0] rd, qa, qd;
    logic qw;
    logic [1:0] qs;
    logic [3:0] qb;
    for (int i = 0; i < 4; i++) begin
      run_access(ops[i], ads[i], 32'h0, 32'h80FF1234, 1, 1, s, v, rd, qa, qw, qs, qb, qd, rq);
      checks++;
      if (rd !== exp[i] || v !== 1) begin
        failures++; $display("FAIL load_ext[%0d] got=%h vcnt=%0d exp=%h/1", i, rd, v, exp[i]);
      end
      checks++;
      if (qs !== m_size(ops[i]) || qa !== ads[i]) begin
        failures++; $display("FAIL load_ext_req[%0d] got size=%0d addr=%h exp %0d/%h", i, qs, qa, m_size(ops[i]), ads[i]);
      end
    end
  endtask

  task automatic test_store_format();
    int s, v, rq;
    logic [31:0] rd, qa, qd;
    logic qw;
    logic [1:0] qs;
    logic [3:0] qb;
    run_access(EXE_SH_OP, 32'h202, 32'h0000ABCD, 32'h0, 0, 1, s, v, rd, qa, qw, qs, qb, qd, rq);
    checks++;
    if ({qw, qs, qb} !== {1'b1, 2'd1, 4'b1100} || qd !== 32'hABCDABCD) begin
      failures++; $display("FAIL sh_format got wr=%b size=%0d wstrb=%b wdata=%h exp 1/1/1100/abcdabcd", qw, qs, qb, qd);
    end
    checks++;
    if (v !== 0 || s !== 3) begin failures++; $display("FAIL sh_timing got vcnt=%0d stalls=%0d exp 0/3", v, s); end
    run_access(EXE_SB_OP, 32'h201, 32'h0000005A, 32'h0, 2, 0, s, v, rd, qa, qw, qs, qb, qd, rq);
    checks++;
    if ({qw, qs, qb} !== {1'b1, 2'd0, 4'b0010} || qd !== 32'h5A5A5A5A || qa !== 32'h201) begin
      failures++; $display("FAIL sb_format got wr=%b size=%0d wstrb=%b wdata=%h addr=%h exp 1/0/0010/5a5a5a5a/201", qw, qs, qb, qd, qa);
    end
    checks++;
    if (s !== 4 || rq !== 3) begin failures++; $display("FAIL sb_timing got stalls=%0d reqcyc=%0d exp 4/3", s, rq); end
  endtask

  task automatic test_misaligned();
    bit req_seen;
    req_seen = 1'b0;
    valid_i = 1'b1; op_i = EXE_LW_OP; addr_i = 32'h101; wdata_i = 32'h0;
    #4;
    checks++;
    if ({adel_o, ades_o, stall_o, bus.data_req} !== 4'b1000 || badvaddr_o !== 32'h101) begin
      failures++; $display("FAIL lw_misalign got adel=%b ades=%b stall=%b req=%b bad=%h exp 1/0/0/0/101",
                           adel_o, ades_o, stall_o, bus.data_req, badvaddr_o);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(); #4;
      if (bus.data_req || stall_o) req_seen = 1'b1;
    end
    checks++;
    if (req_seen) begin failures++; $display("FAIL lw_misalign_noreq got=1 exp=0"); end
    cyc();
    op_i = EXE_SH_OP; addr_i = 32'h203;
    #4;
    checks++;
    if ({adel_o, ades_o, stall_o} !== 3'b010 || badvaddr_o !== 32'h203) begin
      failures++; $display("FAIL sh_misalign got adel=%b ades=%b stall=%b bad=%h exp 0/1/0/203",
                           adel_o, ades_o, stall_o, badvaddr_o);
    end
    cyc();
    valid_i = 1'b0;
    cyc();
  endtask

  task automatic test_flush_drain();
    int s, v, rq;
    logic [31:0] rd, qa, qd;
    logic qw;
    logic [1:0] qs;
    logic [3:0] qb;
    bit vseen;
    vseen = 1'b0;
    valid_i = 1'b1; op_i = EXE_LW_OP; addr_i = 32'h100; flush_i = 1'b0;
    cyc();                                   // request phase
    bus.data_addr_ok = 1'b1;
    #4; if (rdata_valid_o) vseen = 1'b1;
    cyc();                                   // waiting for data: flush arrives
    bus.data_addr_ok = 1'b0; flush_i = 1'b1;
    #4; if (rdata_valid_o) vseen = 1'b1;
    cyc();                                   // a store is now presented
    flush_i = 1'b0; valid_i = 1'b1; op_i = EXE_SW_OP; addr_i = 32'h300; wdata_i = 32'h13572468;
    #4;
    checks++;
    if (stall_o !== 1'b1 || bus.data_req !== 1'b0) begin
      failures++; $display("FAIL drain_hold got stall=%b req=%b exp 1/0", stall_o, bus.data_req);
    end
    if (rdata_valid_o) vseen = 1'b1;
    cyc();                                   // late response of the flushed load
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFEF00D;
    #4;
    checks++;
    if (stall_o !== 1'b1 || bus.data_req !== 1'b0) begin
      failures++; $display("FAIL drain_resp got stall=%b req=%b exp 1/0", stall_o, bus.data_req);
    end
    if (rdata_valid_o) vseen = 1'b1;
    cyc();
    bus.data_data_ok = 1'b0;
    run_access(EXE_SW_OP, 32'h300, 32'h13572468, 32'h0, 0, 1, s, v, rd, qa, qw, qs, qb, qd, rq);
    checks++;
    if (vseen || v !== 0) begin failures++; $display("FAIL drain_no_valid got=1 exp=0"); end
    checks++;
    if (s !== 3 || qa !== 32'h300 || {qw, qs, qb} !== {1'b1, 2'd2, 4'b1111} || qd !== 32'h13572468) begin
      failures++; $display("FAIL sw_after_drain got stalls=%0d addr=%h wr=%b size=%0d wstrb=%b wdata=%h exp 3/300/1/2/1111/13572468",
                           s, qa, qw, qs, qb, qd);
    end
    #4;
    checks++;
    if (rdata_o === 32'hCAFEF00D) begin failures++; $display("FAIL drain_rdata got=%h exp=not cafef00d", rdata_o); end
    cyc();
  endtask

  task automatic test_reset_mid();
    int s, v, rq;
    logic [31:0] rd, qa, qd;
    logic qw;
    logic [1:0] qs;
    logic [3:0] qb;
    valid_i = 1'b1; op_i = EXE_LW_OP; addr_i = 32'h140;
    cyc();                                   // request outstanding, no addr_ok
    rst = 1'b1;
    cyc();
    rst = 1'b0; valid_i = 1'b0;
    #4;
    checks++;
    if (bus.data_req !== 1'b0 || stall_o !== 1'b0 || rdata_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_mid got req=%b stall=%b valid=%b exp 0/0/0", bus.data_req, stall_o, rdata_valid_o);
    end
    cyc();
    run_access(EXE_LW_OP, 32'h144, 32'h0, 32'h0BADC0DE, 2, 2, s, v, rd, qa, qw, qs, qb, qd, rq);
    checks++;
    if (s !== 6 || v !== 1 || rd !== 32'h0BADC0DE || qa !== 32'h144) begin
      failures++; $display("FAIL lw_after_reset got stalls=%0d vcnt=%0d rdata=%h addr=%h exp 6/1/0badc0de/144", s, v, rd, qa);
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [9] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
                            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, 8'h25};
    int s, v, rq, al, dl, n;
    logic [31:0] rd, qa, qd, a, d, w;
    logic qw;
    logic [1:0] qs;
    logic [3:0] qb;
    logic [7:0] op;
    bit mem;
    for (int it = 0; it < 40; it++) begin
      op = ops[$urandom_range(0, 8)];
      a  = $urandom;
      d  = $urandom;
      w  = $urandom;
      al = $urandom_range(0, 3);
      dl = $urandom_range(0, 3);
      n  = m_bytes(op);
      if ($urandom_range(0, 2) != 0) a = a & ~32'(n - 1);
      mem = m_is_load(op) || m_is_store(op);
      if (!mem || !m_aligned(op, a)) begin
        valid_i = 1'b1; op_i = op; addr_i = a; wdata_i = d;
        #4;
        checks++;
        if (adel_o !== (mem && m_is_load(op)) || ades_o !== (mem && m_is_store(op)) ||
            stall_o !== 1'b0 || bus.data_req !== 1'b0 || badvaddr_o !== (mem ? a : 32'h0)) begin
          failures++; $display("FAIL rand_noaccess[%0d] op=%h addr=%h got adel=%b ades=%b stall=%b bad=%h",
                               it, op, a, adel_o, ades_o, stall_o, badvaddr_o);
        end
        cyc();
        valid_i = 1'b0;
        cyc();
      end else begin
        run_access(op, a, d, w, al, dl, s, v, rd, qa, qw, qs, qb, qd, rq);
        checks++;
        if (s !== 1 + (al + 1) + dl || rq !== al + 1 || v !== (m_is_load(op) ? 1 : 0)) begin
          failures++; $display("FAIL rand_timing[%0d] op=%h got stalls=%0d reqcyc=%0d vcnt=%0d exp %0d/%0d/%0d",
                               it, op, s, rq, v, 1 + al + 1 + dl, al + 1, m_is_load(op) ? 1 : 0);
        end
        checks++;
        if (qa !== a || qw !== m_is_store(op) || qs !== m_size(op) || qb !== m_wstrb(op, a) ||
            (m_is_store(op) && qd !== m_wdata(op, d))) begin
          failures++; $display("FAIL rand_req[%0d] op=%h got addr=%h wr=%b size=%0d wstrb=%b wdata=%h exp %h/%b/%0d/%b/%h",
                               it, op, qa, qw, qs, qb, qd, a, m_is_store(op), m_size(op), m_wstrb(op, a), m_wdata(op, d));
        end
        if (m_is_load(op)) begin
          checks++;
          if (rd !== m_load(op, a, w)) begin
            failures++; $display("FAIL rand_load[%0d] op=%h addr=%h word=%h got=%h exp=%h", it, op, a, w, rd, m_load(op, a, w));
          end
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw_latency();
    test_load_ext();
    test_store_format();
    test_misaligned();
    test_flush_drain();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
